// File: rtl/key_serializer.sv
// Keyboard scancode serializer: buffers bytes in a small FIFO and emits
// UART-style frames (start, 8 data LSB first, odd parity, stop) to the encryptor.

module key_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [7:0]   wr_data,
  input  logic         pop,
  output logic [7:0]   rd_data,
  output logic [AW:0]  count
);
  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

module key_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   key_data,
  input  logic                         key_valid,
  output logic                         key_ready,
  output logic                         ser_out,
  output logic                         bit_strobe,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]     LAST_CNT = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic [7:0] sh;
    logic       par;
    logic [2:0] idx;
    logic [7:0] cnt;
  } frame_t;

  typedef struct packed {
    logic ser;
    logic strobe;
    logic busy;
  } out_t;

  state_t     st, st_d;
  frame_t     fr, fr_d;
  out_t       out_q, out_d;
  logic       push, pop, last, load;
  logic [7:0] head;

  assign key_ready = (fifo_count < FULL);
  assign push      = key_valid & key_ready;

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (key_data),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign last = (fr.cnt == LAST_CNT);
  // A new frame starts from IDLE or straight out of the final STOP cycle.
  assign load = (fifo_count != '0) && ((st == IDLE) || ((st == STOP) && last));

  always_comb begin
    st_d = st;
    fr_d = fr;
    pop  = 1'b0;
    case (st)
      IDLE: ;
      START: begin
        if (last) begin
          fr_d.cnt = '0;
          st_d     = DATA;
        end else fr_d.cnt = fr.cnt + 8'd1;
      end
      DATA: begin
        if (last) begin
          fr_d.cnt = '0;
          fr_d.sh  = {1'b0, fr.sh[7:1]};
          fr_d.idx = fr.idx + 3'd1;
          if (fr.idx == 3'd7) st_d = PARITY;
        end else fr_d.cnt = fr.cnt + 8'd1;
      end
      PARITY: begin
        if (last) begin
          fr_d.cnt = '0;
          st_d     = STOP;
        end else fr_d.cnt = fr.cnt + 8'd1;
      end
      STOP: begin
        if (last) begin
          fr_d.cnt = '0;
          st_d     = IDLE;
        end else fr_d.cnt = fr.cnt + 8'd1;
      end
      default: st_d = IDLE;
    endcase
    if (load) begin
      pop      = 1'b1;
      st_d     = START;
      fr_d.sh  = head;
      fr_d.par = ~^head;
      fr_d.idx = '0;
      fr_d.cnt = '0;
    end
  end

  // Line outputs are a registered decode of the FSM, one cycle behind it.
  always_comb begin
    out_d.busy   = (st != IDLE);
    out_d.strobe = (st != IDLE) && (fr.cnt == '0);
    case (st)
      START:   out_d.ser = 1'b0;
      DATA:    out_d.ser = fr.sh[0];
      PARITY:  out_d.ser = fr.par;
      default: out_d.ser = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st    <= IDLE;
      fr    <= '0;
      out_q <= '{ser: 1'b1, strobe: 1'b0, busy: 1'b0};
    end else begin
      st    <= st_d;
      fr    <= fr_d;
      out_q <= out_d;
    end
  end

  assign ser_out    = out_q.ser;
  assign bit_strobe = out_q.strobe;
  assign busy       = out_q.busy;
endmodule

// File: tb/tb_key_serializer.sv
// Scoreboard bench for key_serializer: stimulus queues expected frames,
// a negedge monitor checks every line cycle against them.

module tb_key_serializer;
  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] key_data, k1_data;
  logic       key_valid, k1_valid;
  logic       key_ready, ser_out, bit_strobe, busy;
  logic [2:0] fifo_count;
  logic       ready1, ser1, strobe1, busy1;
  logic [2:0] count1;

  always #5 clock = ~clock;

  key_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .key_data(key_data), .key_valid(key_valid),
    .key_ready(key_ready), .ser_out(ser_out), .bit_strobe(bit_strobe),
    .busy(busy), .fifo_count(fifo_count)
  );

  key_serializer #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
    .clock(clock), .reset(reset), .key_data(k1_data), .key_valid(k1_valid),
    .key_ready(ready1), .ser_out(ser1), .bit_strobe(strobe1),
    .busy(busy1), .fifo_count(count1)
  );

  int          n_chk = 0, n_pass = 0;
  logic [10:0] exp_q[$];
  int          starts[$];
  int          frames_seen = 0;
  int          cyc = 0;
  int          fpos = -1;
  logic [10:0] cur;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: frame bit i is expected on ser_out for CPB cycles starting at its strobe.
  always @(negedge clock) begin
    if (reset) fpos = -1;
    else if (fpos < 0) begin
      if (bit_strobe) begin
        chk("frame_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          fpos = 0;
          starts.push_back(cyc);
          frames_seen++;
        end
      end else begin
        chk("idle_ser", ser_out, 1);
        chk("idle_busy", busy, 0);
      end
    end
    if (!reset && fpos >= 0) begin
      chk("ser_bit", ser_out, cur[fpos/CPB]);
      chk("strobe", bit_strobe, int'(fpos % CPB == 0));
      chk("busy", busy, 1);
      fpos++;
      if (fpos == 11*CPB) fpos = -1;
    end
  end

  task automatic send(input logic [7:0] b, input logic [10:0] e);
    int w = 0;
    key_data = b;
    key_valid = 1'b1;
    while (!key_ready && w < 200) begin @(negedge clock); w++; end
    chk("send_accept", key_ready, 1);
    if (key_ready) exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic drain();
    int w = 0;
    key_valid = 1'b0;
    while (w < 1000 && !(exp_q.size() == 0 && fpos < 0 && fifo_count == 0 && !busy)) begin
      @(negedge clock);
      w++;
    end
    chk("drain_in_time", int'(w < 1000), 1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, f0, w;
    bit          saw_full, saw_rise, was_full, took;
    logic [7:0]  d;
    logic [10:0] e1;

    reset = 1'b1; key_valid = 1'b1; key_data = 8'h99;
    k1_valid = 1'b0; k1_data = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_ser", ser_out, 1);
    chk("rst_strobe", bit_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", key_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_ser1", ser1, 1);
    chk("rst_ready1", ready1, 1);
    reset = 1'b0; key_valid = 1'b0;
    @(negedge clock);
    chk("rst_push_dropped", fifo_count, 0);

    // Single byte + latency
    send(8'hA5, 11'b1_1_10100101_0);
    key_valid = 1'b0;
    chk("lat_count1", fifo_count, 1);
    chk("lat_ser_n0", ser_out, 1);
    chk("lat_strb_n0", bit_strobe, 0);
    @(negedge clock);
    chk("lat_ser_n1", ser_out, 1);
    chk("lat_strb_n1", bit_strobe, 0);
    chk("lat_busy_n1", busy, 0);
    chk("lat_count0", fifo_count, 0);
    @(negedge clock);
    chk("lat_ser_n2", ser_out, 0);
    chk("lat_strb_n2", bit_strobe, 1);
    drain();

    // Parity corners
    send(8'h00, 11'b1_1_00000000_0); drain();
    send(8'h07, 11'b1_0_00000111_0); drain();
    send(8'hFF, 11'b1_1_11111111_0); drain();

    // Back-to-back, frames must abut
    starts.delete();
    send(8'h12, 11'b1_1_00010010_0);
    send(8'h34, 11'b1_0_00110100_0);
    send(8'h56, 11'b1_1_01010110_0);
    drain();
    chk("b2b_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("b2b_gap1", starts[1] - starts[0], 44);
      chk("b2b_gap2", starts[2] - starts[1], 44);
    end

    // Full FIFO with key_valid held high
    acc = 0; saw_full = 0; saw_rise = 0; was_full = 0; d = 8'h40;
    f0 = frames_seen;
    key_valid = 1'b1; key_data = d;
    for (int i = 0; i < 120; i++) begin
      chk("ready_vs_count", key_ready, int'(fifo_count < 4));
      if (fifo_count == 4) saw_full = 1;
      if (was_full && key_ready) saw_rise = 1;
      was_full = (fifo_count == 4);
      took = key_ready;
      if (took) begin exp_q.push_back({1'b1, ~^d, d, 1'b0}); acc++; end
      @(posedge clock); #1;
      if (took) begin d = d + 8'd1; key_data = d; end
      @(negedge clock);
    end
    drain();
    chk("full_seen", saw_full, 1);
    chk("full_ready_rise", saw_rise, 1);
    chk("full_bytes_sent", frames_seen - f0, acc);

    // Reset mid-frame during DATA bit 3 with two bytes queued
    send(8'hC3, 11'b1_1_11000011_0);
    send(8'h3C, 11'b1_1_00111100_0);
    send(8'h81, 11'b1_1_10000001_0);
    key_valid = 1'b0;
    w = 0;
    while (fpos != 17 && w < 200) begin @(posedge clock); #1; w++; end
    chk("mid_reach_bit3", fpos, 17);
    chk("mid_queued", fifo_count, 2);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    chk("mid_ser", ser_out, 1);
    chk("mid_busy", busy, 0);
    chk("mid_count", fifo_count, 0);
    chk("mid_strobe", bit_strobe, 0);
    reset = 1'b0;
    f0 = frames_seen;
    repeat (150) @(negedge clock);
    chk("mid_no_frames", frames_seen - f0, 0);
    chk("mid_count_end", fifo_count, 0);

    // CPB=1: strobe on every bit cycle
    e1 = 11'b1_1_01010101_0;
    @(negedge clock);
    k1_data = 8'h55; k1_valid = 1'b1;
    @(negedge clock);
    k1_valid = 1'b0;
    @(negedge clock);
    chk("c1_pre_ser", ser1, 1);
    chk("c1_pre_strobe", strobe1, 0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      chk("c1_strobe", strobe1, 1);
      chk("c1_ser", ser1, e1[i]);
      chk("c1_busy", busy1, 1);
    end
    @(negedge clock);
    chk("c1_end_busy", busy1, 0);
    chk("c1_end_ser", ser1, 1);
    chk("c1_end_strobe", strobe1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
